cache_assoc: RTL

Parametrised N-way set-associative, write-back, write-allocate cache with byte-enable writes. It is the successor to the direct-mapped instruction/data cache and sits between a CPU load/store port and a single-word SRAM. Compared with that cache it adds:
- configurable address width, set count and associativity;
- round-robin replacement that prefers invalid ways;
- dirty-victim writeback;
- an explicit memory acknowledge handshake.

---
 rtl/cache_assoc_if.sv | 34 +++
 rtl/cache_assoc.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_assoc_if.sv
// CPU-side and memory-side bus bundle for cache_assoc.
// slave = cache side, master = CPU/memory side.
interface cache_assoc_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] address;
  logic [31:0]       data_in_cpu;
  logic              rd;
  logic [3:0]        wr;
  logic              hit_miss;
  logic [31:0]       data2cpu;
  logic              data_ready;
  logic [31:0]       data_in_mem;
  logic              mem_ack;
  logic [31:0]       data2mem;
  logic [ADDR_W-1:0] m_rd_address;
  logic [ADDR_W-1:0] m_wr_address;
  logic              mrden;
  logic              mwren;
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;

  modport slave (
    input  address, data_in_cpu, rd, wr, data_in_mem, mem_ack,
    output hit_miss, data2cpu, data_ready, data2mem, m_rd_address, m_wr_address,
           mrden, mwren, hit_count, miss_count
  );

  modport master (
    output address, data_in_cpu, rd, wr, data_in_mem, mem_ack,
    input  hit_miss, data2cpu, data_ready, data2mem, m_rd_address, m_wr_address,
           mrden, mwren, hit_count, miss_count
  );
endinterface

// File: rtl/cache_assoc.sv
// N-way set-associative write-back, write-allocate cache, one 32-bit word per line.
// Optional hit/miss counters enabled by defining CACHE_PERF_CNT_EN.
module cache_assoc #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned SET_BITS = 6,
  parameter int unsigned WAYS     = 2
) (
  input logic          clk,
  input logic          rst,
  cache_assoc_if.slave bus
);
  localparam int unsigned TAG_W = ADDR_W - SET_BITS - 2;
  localparam int unsigned SETS  = 1 << SET_BITS;
  localparam int unsigned PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {StIdle, StLookup, StWb, StRefill, StResp} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-3:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic [PTR_W-1:0]    victim_q, victim_d;
  logic [31:0]         resp_data_q, resp_data_d;
  logic                hit_miss_q, hit_miss_d;

  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     dirty_q [SETS];
  logic [PTR_W-1:0]    ptr_q   [SETS];
  logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
  logic [31:0]         data_q  [SETS][WAYS];

  logic [SET_BITS-1:0] idx;
  logic [TAG_W-1:0]    req_tag;
  logic                hit;
  logic [PTR_W-1:0]    hit_way;
  logic                inv_found;
  logic [PTR_W-1:0]    inv_way;

  // Array write port requests from the FSM.
  logic                arr_we;
  logic [PTR_W-1:0]    arr_way;
  logic [31:0]         arr_data;
  logic                arr_dirty;
  logic                fill_we;
  logic                ptr_we;
  logic                cnt_hit;
  logic                cnt_miss;

  logic                data_ready;
  logic                mrden;
  logic                mwren;
  logic [ADDR_W-1:0]   m_rd_address;
  logic [ADDR_W-1:0]   m_wr_address;
  logic [31:0]         data2mem;

  logic                unused_addr;
  assign unused_addr = ^bus.address[1:0];

  assign idx     = addr_q[SET_BITS-1:0];
  assign req_tag = addr_q[ADDR_W-3:SET_BITS];

  function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[idx][w] && (tag_q[idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = PTR_W'(w);
      end
    end
    // Scan downward so the lowest-index invalid way is the one left standing.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        inv_found = 1'b1;
        inv_way   = PTR_W'(w);
      end
    end
  end

  always_comb begin
    logic [31:0] merged;
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    victim_d     = victim_q;
    hit_miss_d   = hit_miss_q;
    resp_data_d  = resp_data_q;
    arr_we       = 1'b0;
    arr_way      = victim_q;
    arr_data     = '0;
    arr_dirty    = 1'b0;
    fill_we      = 1'b0;
    ptr_we       = 1'b0;
    cnt_hit      = 1'b0;
    cnt_miss     = 1'b0;
    data_ready   = 1'b0;
    mrden        = 1'b0;
    mwren        = 1'b0;
    m_rd_address = '0;
    m_wr_address = '0;
    data2mem     = '0;
    merged       = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.rd || (bus.wr != 4'b0)) begin
          addr_d  = bus.address[ADDR_W-1:2];
          wdata_d = bus.data_in_cpu;
          be_d    = bus.wr;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (hit) begin
          merged      = merge(data_q[idx][hit_way], wdata_q, be_q);
          data_ready  = 1'b1;
          hit_miss_d  = 1'b1;
          resp_data_d = merged;
          cnt_hit     = 1'b1;
          if (be_q != 4'b0) begin
            arr_we    = 1'b1;
            arr_way   = hit_way;
            arr_data  = merged;
            arr_dirty = 1'b1;
          end
          state_d = StIdle;
        end else begin
          cnt_miss = 1'b1;
          if (inv_found) begin
            victim_d = inv_way;
            state_d  = StRefill;
          end else begin
            victim_d = ptr_q[idx];
            ptr_we   = 1'b1;
            state_d  = dirty_q[idx][ptr_q[idx]] ? StWb : StRefill;
          end
        end
      end
      StWb: begin
        mwren        = 1'b1;
        m_wr_address = {tag_q[idx][victim_q], idx, 2'b00};
        data2mem     = data_q[idx][victim_q];
        if (bus.mem_ack) state_d = StRefill;
      end
      StRefill: begin
        mrden        = 1'b1;
        m_rd_address = {addr_q, 2'b00};
        if (bus.mem_ack) begin
          fill_we   = 1'b1;
          arr_we    = 1'b1;
          arr_data  = bus.data_in_mem;
          arr_dirty = 1'b0;
          state_d   = StResp;
        end
      end
      StResp: begin
        merged      = merge(data_q[idx][victim_q], wdata_q, be_q);
        data_ready  = 1'b1;
        hit_miss_d  = 1'b0;
        resp_data_d = merged;
        if (be_q != 4'b0) begin
          arr_we    = 1'b1;
          arr_data  = merged;
          arr_dirty = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      victim_q    <= '0;
      resp_data_q <= '0;
      hit_miss_q  <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      victim_q    <= victim_d;
      resp_data_q <= resp_data_d;
      hit_miss_q  <= hit_miss_d;
      if (arr_we) dirty_q[idx][arr_way] <= arr_dirty;
      if (fill_we) valid_q[idx][victim_q] <= 1'b1;
      if (ptr_we) begin
        ptr_q[idx] <= (ptr_q[idx] == PTR_W'(WAYS - 1)) ? '0 : ptr_q[idx] + PTR_W'(1);
      end
    end
  end

  // Tag and data payload need no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (arr_we) data_q[idx][arr_way] <= arr_data;
    if (fill_we) tag_q[idx][victim_q] <= req_tag;
  end

  assign bus.data_ready   = data_ready;
  assign bus.hit_miss     = data_ready ? hit_miss_d : hit_miss_q;
  assign bus.data2cpu     = data_ready ? resp_data_d : resp_data_q;
  assign bus.mrden        = mrden;
  assign bus.mwren        = mwren;
  assign bus.m_rd_address = m_rd_address;
  assign bus.m_wr_address = m_wr_address;
  assign bus.data2mem     = data2mem;

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q + {31'b0, cnt_hit};
    miss_cnt_d = miss_cnt_q + {31'b0, cnt_miss};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt     = cnt_hit ^ cnt_miss;
  assign bus.hit_count  = '0;
  assign bus.miss_count = '0;
`endif

endmodule
